// File: rtl/clock_meter_pkg.sv
// Shared definitions for the clock ratio meter and the divider bench that
// reuses its default constants.
package clock_meter_pkg;

  // Default counter width, stall timeout and lock depth.
  localparam int unsigned DEFAULT_WIDTH      = 32;
  localparam int unsigned DEFAULT_TIMEOUT    = 1048576;
  localparam int unsigned DEFAULT_LOCK_COUNT = 4;

  // IDLE waits for the first rising edge of a new run.
  // MEASURE reports every complete slow period.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, followed by a delay flop.
// It produces the synchronized level and a single-cycle rising-edge strobe.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // r_s1/r_s2 resolve metastability; r_s3 holds the previous synchronized level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures a slow clock against clk_in. It reports the period and the high
// time in clk_in cycles. It flags lock after a run of identical periods, and
// it flags a stall when no slow rising edge has been seen for TIMEOUT cycles.
module clock_ratio_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int unsigned LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             slow_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_count,
  output logic             meas_valid,
  output logic             locked,
  output logic             stalled
);

  localparam logic [WIDTH-1:0] C_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_TIMEOUT  = WIDTH'(TIMEOUT);

  // The streak only needs to count up to LOCK_COUNT; it saturates there.
  localparam int unsigned      SW         = $clog2(LOCK_COUNT + 1);
  localparam logic [SW-1:0]    C_LOCK     = SW'(LOCK_COUNT);
  localparam logic [SW-1:0]    C_S_ONE    = SW'(1);

  logic             w_level;
  logic             w_rise;
  logic             w_match;
  logic [SW-1:0]    w_next_streak;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_count;
  logic             r_meas_valid;
  logic             r_locked;
  logic             r_stalled;
  logic [SW-1:0]    r_streak;
  meter_state_t     r_state;

  sync_edge_detect u_sync (
    .i_clk   (clk_in),
    .i_rst_n (reset_n),
    .i_async (slow_in),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  // Period and high-time counters restart at 1 on each rising edge and saturate at all-ones.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_hcnt <= '0;
    end else if (w_rise) begin
      r_cnt  <= C_ONE;
      r_hcnt <= C_ONE;
    end else begin
      if (r_cnt != C_ALL_ONES) begin
        r_cnt <= r_cnt + C_ONE;
      end
      if (w_level && (r_hcnt != C_ALL_ONES)) begin
        r_hcnt <= r_hcnt + C_ONE;
      end
    end
  end

  // Next streak value if this edge completes a measurement.
  // A zero streak means there is no earlier period to compare against.
  always_comb begin
    w_match       = 1'b0;
    w_next_streak = C_S_ONE;
    if ((r_streak != '0) && (r_cnt == r_period)) begin
      w_match = 1'b1;
    end
    if (w_match) begin
      w_next_streak = (r_streak == C_LOCK) ? r_streak : r_streak + C_S_ONE;
    end
  end

  // Measurement FSM with registered outputs.
  // An edge takes priority over a timeout that lands on the same cycle.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_period     <= '0;
      r_high_count <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_stalled    <= 1'b0;
      r_streak     <= '0;
    end else begin
      r_meas_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state   <= ST_MEASURE;
            r_stalled <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            r_period     <= r_cnt;
            r_high_count <= r_hcnt;
            r_meas_valid <= 1'b1;
            r_streak     <= w_next_streak;
            r_locked     <= (w_next_streak >= C_LOCK);
          end else if (r_cnt == C_TIMEOUT) begin
            r_state   <= ST_IDLE;
            r_stalled <= 1'b1;
            r_locked  <= 1'b0;
            r_streak  <= '0;
          end
        end
      endcase
    end
  end

  assign period     = r_period;
  assign high_count = r_high_count;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign stalled    = r_stalled;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Bench for clock_ratio_meter. Two instances share the clock and the reset.
// dut0 (TIMEOUT 200, LOCK_COUNT 4) covers ratios, lock and reset behaviour.
// dut1 (TIMEOUT 64, LOCK_COUNT 1) covers stall detection and restart.
module tb_clock_ratio_meter;
  import clock_meter_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  typedef struct {
    logic [W-1:0] period;
    logic [W-1:0] high;
    logic         locked;
    int           cyc;
  } exp_t;

  logic         clk_in = 1'b0;
  logic         reset_n;
  logic         slow0;
  logic         slow1;
  logic [W-1:0] period0, high0, period1, high1;
  logic         valid0, locked0, stalled0;
  logic         valid1, locked1, stalled1;

  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatched = 0;
  exp_t q0[$];
  exp_t q1[$];

  // Reference model state, one entry per instance.
  int   prevHigh[2];
  int   prevLow[2];
  int   prevP[2];
  int   streak[2];
  int   lastRise[2];
  bit   armed[2];
  int   lockCnt[2] = '{4, 1};

  clock_ratio_meter #(.WIDTH(W), .TIMEOUT(200), .LOCK_COUNT(4)) dut0 (
    .clk_in(clk_in), .reset_n(reset_n), .slow_in(slow0),
    .period(period0), .high_count(high0), .meas_valid(valid0),
    .locked(locked0), .stalled(stalled0)
  );

  clock_ratio_meter #(.WIDTH(W), .TIMEOUT(64), .LOCK_COUNT(1)) dut1 (
    .clk_in(clk_in), .reset_n(reset_n), .slow_in(slow1),
    .period(period1), .high_count(high1), .meas_valid(valid1),
    .locked(locked1), .stalled(stalled1)
  );

  // 10 ns reference clock.
  always #5 clk_in = ~clk_in;

  // Free-running cycle counter used to check the meas_valid latency.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setSlow(input int sel, input logic v);
    if (sel == 0) slow0 = v;
    else slow1 = v;
  endtask

  task automatic resetModel(input int sel);
    armed[sel]  = 1'b0;
    streak[sel] = 0;
  endtask

  // Drives one slow period (rise, hi cycles high, lo cycles low), starting at a negedge.
  // Each rise reports the previous period once the instance is armed.
  task automatic applyStimulus(input int sel, input int hi, input int lo);
    exp_t e;
    int   p;
    if (armed[sel]) begin
      p = prevHigh[sel] + prevLow[sel];
      if (streak[sel] != 0 && p == prevP[sel])
        streak[sel] = (streak[sel] < lockCnt[sel]) ? streak[sel] + 1 : streak[sel];
      else
        streak[sel] = 1;
      prevP[sel] = p;
      e.period = W'(p);
      e.high   = W'(prevHigh[sel]);
      e.locked = (streak[sel] >= lockCnt[sel]);
      e.cyc    = cyc + 3;
      if (sel == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    armed[sel]    = 1'b1;
    lastRise[sel] = cyc;
    prevHigh[sel] = hi;
    prevLow[sel]  = lo;
    setSlow(sel, 1'b1);
    repeat (hi) @(negedge clk_in);
    setSlow(sel, 1'b0);
    repeat (lo) @(negedge clk_in);
  endtask

  // Scoreboard for dut0: every meas_valid pops one expected measurement.
  always @(negedge clk_in) begin
    exp_t e;
    if (reset_n === 1'b1 && valid0 === 1'b1) begin
      if (q0.size() == 0) begin
        checkOutput("dut0 unexpected meas_valid", W'(valid0), W'(0));
      end else begin
        e = q0.pop_front();
        checkOutput("dut0 period", period0, e.period);
        checkOutput("dut0 high_count", high0, e.high);
        checkOutput("dut0 locked", W'(locked0), W'(e.locked));
        checkOutput("dut0 valid cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  // Scoreboard for dut1.
  always @(negedge clk_in) begin
    exp_t e;
    if (reset_n === 1'b1 && valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        checkOutput("dut1 unexpected meas_valid", W'(valid1), W'(0));
      end else begin
        e = q1.pop_front();
        checkOutput("dut1 period", period1, e.period);
        checkOutput("dut1 high_count", high1, e.high);
        checkOutput("dut1 locked", W'(locked1), W'(e.locked));
        checkOutput("dut1 valid cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    int c;
    reset_n = 1'b0;
    slow0   = 1'b0;
    slow1   = 1'b0;
    resetModel(0);
    resetModel(1);
    #1;
    checkOutput("reset period", period0, W'(0));
    checkOutput("reset high_count", high0, W'(0));
    checkOutput("reset meas_valid", W'(valid0), W'(0));
    checkOutput("reset locked", W'(locked0), W'(0));
    checkOutput("reset stalled", W'(stalled1), W'(0));
    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);

    $display("[TB] ratio 10, 50%% duty");
    repeat (6) applyStimulus(0, 5, 5);
    $display("[TB] ratio 100 then 50");
    repeat (5) applyStimulus(0, 50, 50);
    repeat (6) applyStimulus(0, 25, 25);
    $display("[TB] ratio 2");
    repeat (6) applyStimulus(0, 1, 1);
    $display("[TB] ratio 10, high 3");
    repeat (4) applyStimulus(0, 3, 7);
    repeat (6) applyStimulus(0, 5, 5);

    $display("[TB] reset mid-period");
    applyStimulus(0, 5, 2);
    checkOutput("pre-reset locked", W'(locked0), W'(streak[0] >= lockCnt[0]));
    checkOutput("pre-reset period", period0, W'(10));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset period", period0, W'(0));
    checkOutput("async reset high_count", high0, W'(0));
    checkOutput("async reset meas_valid", W'(valid0), W'(0));
    checkOutput("async reset locked", W'(locked0), W'(0));
    checkOutput("async reset stalled", W'(stalled0), W'(0));
    resetModel(0);
    resetModel(1);
    @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    repeat (3) applyStimulus(0, 5, 5);

    $display("[TB] stall with TIMEOUT 64");
    repeat (4) applyStimulus(1, 4, 4);
    c = lastRise[1];
    while (cyc < c + 66) @(negedge clk_in);
    checkOutput("stalled before timeout", W'(stalled1), W'(0));
    @(negedge clk_in);
    checkOutput("stalled at timeout", W'(stalled1), W'(1));
    checkOutput("locked after timeout", W'(locked1), W'(0));
    checkOutput("period held after timeout", period1, W'(8));
    resetModel(1);
    repeat (5) @(negedge clk_in);
    applyStimulus(1, 4, 4);
    checkOutput("stalled after restart", W'(stalled1), W'(0));
    applyStimulus(1, 4, 4);
    applyStimulus(1, 4, 4);

    repeat (8) @(negedge clk_in);
    checkOutput("dut0 queue drained", W'(q0.size()), W'(0));
    checkOutput("dut1 queue drained", W'(q1.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/clock_ratio_meter.md
# clock_ratio_meter

Measures an incoming slow clock against the fast reference clock and reports the division ratio: clk_in cycles per slow period, plus high-phase cycles, per slow period. It is the receiving end of the clock divider. It checks in system that a divided clock runs at the programmed ratio and duty. It also gives the bench a self-checking monitor in place of free-running counters. It flags lock on a stable ratio and stall on a dead clock.

## Interface
Parameters:
- WIDTH, 32, width of period/high counters and outputs
- TIMEOUT, 1048576, clk_in cycles without a slow rising edge before stall; must be ≤ 2^WIDTH−2
- LOCK_COUNT, 4, consecutive identical periods required for lock; ≥ 1

Ports:
- clk_in  input  1  fast reference clock; only clock
- reset_n  input  1  asynchronous, active-low reset
- slow_in  input  1  clock under measurement; treated as asynchronous
- period  output  WIDTH  clk_in cycles between last two slow rising edges (= divide ratio)
- high_count  output  WIDTH  clk_in cycles slow_in was high within that period
- meas_valid  output  1  one-cycle pulse: period/high_count updated
- locked  output  1  LOCK_COUNT consecutive equal periods seen
- stalled  output  1  no slow rising edge for TIMEOUT cycles

## Operation
- slow_in passes through a 2-flop synchronizer (s1, s2), then a delay flop s3.
- rise = s2 & ~s3.
- Counters cnt and hcnt.
  - On rise: cnt ← 1, hcnt ← 1.
  - Otherwise: cnt ← cnt+1, saturating at 2^WIDTH−1; hcnt ← hcnt + s2, saturating.
- States:
  - IDLE is the state after reset and after a timeout.
  - In IDLE, rise → MEASURE. No meas_valid, because the first period is partial. stalled clears.
  - In MEASURE, on rise: period ← cnt, high_count ← hcnt, meas_valid ← 1.
  - In MEASURE, if cnt == TIMEOUT with no rise → IDLE. stalled ← 1, locked ← 0, no meas_valid.
- Lock:
  - Streak counter increments when a new period equals the previous one. It resets to 1 on mismatch, and the first valid measurement counts 1.
  - locked rises with the meas_valid that completes LOCK_COUNT identical periods.
  - locked falls with the meas_valid of a mismatching period.
  - LOCK_COUNT = 1 → locked on every valid measurement.
- period and high_count hold their last values across timeout. They are only overwritten on meas_valid.
- Minimum measurable ratio is 2, because slow_in must be low for at least one sampled cycle.
- Glitches shorter than one clk_in cycle may be missed. This is not detected.

## Timing
- Reset values: period = 0, high_count = 0, meas_valid = 0, locked = 0, stalled = 0. State is IDLE, and s1/s2/s3, cnt, hcnt and the streak counter are all 0.
- reset_n low at any time, including mid-period, clears all state asynchronously. Release is followed by IDLE, and the first rise after it is again unreported.
- Latency:
  - slow_in high at clk_in edge e is captured by s1 at e and s2 at e+1.
  - rise is true in the cycle after e+1.
  - Outputs register at e+2, so meas_valid is visible after the third clk_in edge.
- For a divider of ratio R with a steady slow_in, period = R exactly every slow period after the first.
- meas_valid is exactly one cycle wide. A rise on the same cycle cnt reaches TIMEOUT counts as an edge: it is measured, not a stall.
- Saturated cnt or hcnt are reported as all-ones. This only happens if TIMEOUT is misconfigured.

## Structure
- Shared package clock_meter_pkg:
  - state encoding localparams ST_IDLE and ST_MEASURE
  - default WIDTH, TIMEOUT and LOCK_COUNT constants, reused by the divider bench
- Sub-module sync_edge_detect: 2-flop synchronizer plus delay flop, outputs s2 level and rise. It is reusable for other async inputs.
- Top holds the counters, FSM and lock logic. Target is roughly 150–250 lines.

## Test plan
- Ratio 10, 50% duty, LOCK_COUNT = 4:
  - First rise → no meas_valid.
  - Each later rise → period = 10, high_count = 5, meas_valid one cycle, 3 clk_in edges after slow rise.
  - locked asserts on the 4th valid measurement.
- Ratio 100 → 50 switch mid-run:
  - First short period → meas_valid with period = 50 and locked = 0.
  - locked reasserts on the 4th consecutive 50.
- Ratio 2 (slow toggles every clk_in cycle) → period = 2, high_count = 1 steadily.
- Stop slow_in with TIMEOUT = 64 → stalled = 1 exactly 64 cycles after the last counter restart; locked = 0; period holds its last value. On restart, the first rise clears stalled with no meas_valid, and the second rise reports the correct period.
- Assert reset_n low mid-period at ratio 10 → all outputs 0 immediately, without waiting for a clk_in edge. After release, the first rise is not reported and the next reports period = 10.
- Duty check with ratio 10, high for 3 cycles → high_count = 3, period = 10.
